med_feeder: RTL and testbench
=============================

MED_FEEDER -- requirements
Module: med_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which is the pixel and result width in bits.
REQ-002 The block SHALL have parameter N, default 9, which is the number of pixels per window sent to the median engine.
REQ-003 The block SHALL have parameter TIMEOUT, default 63, which is the maximum number of WAIT cycles allowed before an error is flagged.
REQ-004 The block SHALL have port CLK, input, 1 bit: the clock, rising edge active.
REQ-005 The block SHALL have port nRST, input, 1 bit: the reset, asynchronous, active-low.
REQ-006 The block SHALL have port PIX_IN, input, WIDTH bits: the upstream pixel.
REQ-007 The block SHALL have port PIX_VALID, input, 1 bit: PIX_IN is valid.
REQ-008 The block SHALL have port PIX_READY, output, 1 bit: the block accepts a pixel this cycle.
REQ-009 The block SHALL have port MED_DI, output, WIDTH bits: pixel driven to the median engine DI.
REQ-010 The block SHALL have port MED_DSI, output, 1 bit: median engine data strobe in (DSI).
REQ-011 The block SHALL have port MED_DO, input, WIDTH bits: median engine result (DO).
REQ-012 The block SHALL have port MED_DSO, input, 1 bit: median engine result strobe (DSO), a 1-cycle pulse.
REQ-013 The block SHALL have port RES, output, WIDTH bits: the captured median.
REQ-014 The block SHALL have port RES_VALID, output, 1 bit: RES is valid.
REQ-015 The block SHALL have port RES_READY, input, 1 bit: downstream accepts RES.
REQ-016 The block SHALL have port ERR, output, 1 bit: sticky timeout flag.
REQ-017 The block SHALL have port BUSY, output, 1 bit: high in any state other than FILL.

Function
REQ-018 The FSM SHALL have the states FILL, SEND, WAIT and HOLD.
REQ-019 In FILL, PIX_READY SHALL be 1; a pixel SHALL be transferred when PIX_VALID and PIX_READY are both high, and is written to buf[cnt] with cnt incremented.
REQ-020 When the transfer with cnt==N-1 occurs, the FSM SHALL enter SEND on the next edge with cnt=0, and PIX_READY SHALL be 0 in every state other than FILL.
REQ-021 In SEND, MED_DSI SHALL be 1 and MED_DI SHALL equal buf[cnt] for exactly N consecutive cycles in order buf[0]..buf[N-1], after which the FSM enters WAIT.
REQ-022 Outside SEND, MED_DSI SHALL be 0 and MED_DI SHALL be 0, so at least one DSI-low cycle always separates two windows.
REQ-023 In WAIT, the timer SHALL increment every cycle starting from 0; on MED_DSO=1, RES<=MED_DO, the FSM enters HOLD, and the timer clears.
REQ-024 In WAIT, if the timer reaches TIMEOUT without MED_DSO, ERR SHALL be set to 1, the window SHALL be discarded, and the FSM SHALL return to FILL with cnt=0.
REQ-025 A MED_DSO arriving on the same cycle the timer reaches TIMEOUT SHALL win: the result is captured and ERR is not set.
REQ-026 MED_DSO SHALL be ignored in FILL, SEND and HOLD.
REQ-027 In HOLD, RES_VALID SHALL be 1 and RES stable until RES_READY=1; on that edge the FSM enters FILL with cnt=0 and RES_VALID drops the next cycle.
REQ-028 Latency from the last pixel accepted to the first MED_DSI=1 SHALL be 1 cycle, and from MED_DSO to RES_VALID=1 SHALL be 1 cycle.
REQ-029 ERR SHALL remain 1 until reset; it SHALL NOT block operation.
REQ-030 The cnt width SHALL be $clog2(N)+1 bits, and the timer width SHALL be $clog2(TIMEOUT+1) bits with no wrap before the compare.

Reset
REQ-031 When nRST=0, the block SHALL immediately go to state FILL with cnt=0, timer=0, ERR=0, RES=0, RES_VALID=0, MED_DSI=0, MED_DI=0, PIX_READY=1 and BUSY=0.
REQ-032 A reset asserted mid-SEND SHALL drop MED_DSI asynchronously, and the partial window SHALL be lost.
REQ-033 buf contents SHALL need no reset.

Verification
REQ-034 Streaming 9,1,8,2,7,3,6,4,5 with PIX_VALID=1 continuously SHALL give PIX_READY=0 from cycle 10, MED_DSI=1 for 9 cycles with MED_DI in that order, and, with the engine model pulsing DSO and DO=5, RES=5 and RES_VALID=1 one cycle later.
REQ-035 Holding RES_READY=0 for 20 cycles in HOLD SHALL keep RES=5 and RES_VALID=1 stable and PIX_READY=0, and RES_READY=1 SHALL then return the block to FILL with PIX_READY=1.
REQ-036 With the engine silent for 63 WAIT cycles, ERR SHALL become 1, the block SHALL return to FILL, and a following window SHALL still complete correctly with ERR staying 1.
REQ-037 A DSO at exactly timer==TIMEOUT with DO=0xAA SHALL give RES=0xAA and ERR=0.
REQ-038 Toggling PIX_VALID as 1,0,1,0 SHALL fill only on valid cycles, requiring 9 valid transfers before SEND; a spurious DSO during FILL SHALL leave RES_VALID at 0.
REQ-039 Asserting nRST=0 on the 4th SEND cycle SHALL bring MED_DSI=0 immediately and give all outputs their reset values.

Source files
------------

// File: rtl/med_feeder.sv
// ---------------------------------------------------------------------------
// med_feeder
//
// Collects a window of N pixels from an upstream valid/ready stream,
// replays the window to a streaming median engine (DI/DSI), waits a bounded
// time for the engine's result strobe (DO/DSO), and presents the captured
// median downstream on a valid/ready handshake.
//
// Ports
//   CLK        in   clock, rising edge active
//   nRST       in   asynchronous active-low reset
//   PIX_IN     in   upstream pixel
//   PIX_VALID  in   PIX_IN is valid
//   PIX_READY  out  pixel accepted this cycle (only while filling)
//   MED_DI     out  pixel presented to the median engine
//   MED_DSI    out  median engine data strobe
//   MED_DO     in   median engine result
//   MED_DSO    in   median engine result strobe (1-cycle pulse)
//   RES        out  captured median
//   RES_VALID  out  RES is valid
//   RES_READY  in   downstream accepts RES
//   ERR        out  sticky "engine never answered" flag
//   BUSY       out  high whenever the block is not filling
// ---------------------------------------------------------------------------
module med_feeder #(
  parameter int WIDTH   = 8,
  parameter int N       = 9,
  parameter int TIMEOUT = 63
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] PIX_IN,
  input  logic             PIX_VALID,
  output logic             PIX_READY,
  output logic [WIDTH-1:0] MED_DI,
  output logic             MED_DSI,
  input  logic [WIDTH-1:0] MED_DO,
  input  logic             MED_DSO,
  output logic [WIDTH-1:0] RES,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic             ERR,
  output logic             BUSY
);

  localparam int CW = $clog2(N) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [TW-1:0]    timer_q;
  logic [WIDTH-1:0] buf_q [N];
  logic             pixReady_q;
  logic             busy_q;
  logic             medDsi_q;
  logic [WIDTH-1:0] medDi_q;
  logic [WIDTH-1:0] res_q;
  logic             resValid_q;
  logic             err_q;

  logic             pixFire;
  logic [CW-1:0]    cntNext;
  logic [WIDTH-1:0] firstPix;

  assign pixFire = PIX_VALID & pixReady_q;
  assign cntNext = cnt_q + CNT_ONE;

  // With a one-pixel window the first pixel to send is the one arriving
  // right now, since buf[0] is only written on this same edge.
  assign firstPix = (N == 1) ? PIX_IN : buf_q[0];

  // Window storage carries no reset: a stale window is never replayed
  // because cnt always restarts at 0 before filling.
  always_ff @(posedge CLK) begin
    if (pixFire) begin
      buf_q[cnt_q[IW-1:0]] <= PIX_IN;
    end
  end

  // Main controller. All handshake outputs are registered here so they
  // change only on clock edges (or immediately on reset), and MED_DI is
  // preloaded one step ahead of cnt so it always shows buf[cnt].
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      timer_q    <= '0;
      pixReady_q <= 1'b1;
      busy_q     <= 1'b0;
      medDsi_q   <= 1'b0;
      medDi_q    <= '0;
      res_q      <= '0;
      resValid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (pixFire) begin
            if (cnt_q == CNT_LAST) begin
              state_q    <= SEND;
              cnt_q      <= '0;
              pixReady_q <= 1'b0;
              busy_q     <= 1'b1;
              medDsi_q   <= 1'b1;
              medDi_q    <= firstPix;
            end else begin
              cnt_q <= cntNext;
            end
          end
        end

        SEND: begin
          if (cnt_q == CNT_LAST) begin
            state_q  <= WAIT;
            cnt_q    <= '0;
            timer_q  <= '0;
            medDsi_q <= 1'b0;
            medDi_q  <= '0;
          end else begin
            cnt_q   <= cntNext;
            medDi_q <= buf_q[cntNext[IW-1:0]];
          end
        end

        // A result strobe is checked before the timeout so that a DSO on
        // the very last permitted cycle is still captured.
        WAIT: begin
          if (MED_DSO) begin
            state_q    <= HOLD;
            res_q      <= MED_DO;
            resValid_q <= 1'b1;
            timer_q    <= '0;
          end else if (timer_q == TIMER_MAX) begin
            state_q    <= FILL;
            err_q      <= 1'b1;
            cnt_q      <= '0;
            timer_q    <= '0;
            pixReady_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end

        HOLD: begin
          if (RES_READY) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            resValid_q <= 1'b0;
            pixReady_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end

        default: begin
          state_q    <= FILL;
          cnt_q      <= '0;
          pixReady_q <= 1'b1;
          busy_q     <= 1'b0;
          medDsi_q   <= 1'b0;
          medDi_q    <= '0;
        end
      endcase
    end
  end

  assign PIX_READY = pixReady_q;
  assign BUSY      = busy_q;
  assign MED_DSI   = medDsi_q;
  assign MED_DI    = medDi_q;
  assign RES       = res_q;
  assign RES_VALID = resValid_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_med_feeder.sv
// ---------------------------------------------------------------------------
// tb_med_feeder
//
// Directed and randomized bench for med_feeder. The bench plays both the
// upstream pixel source and the median engine: the engine answers with the
// true median of the window it was sent, after a chosen delay. Expected
// values come from the window contents and the timing rules (a strobe on
// WAIT cycle d is captured iff d <= TIMEOUT, otherwise the window times out).
// ---------------------------------------------------------------------------
module tb_med_feeder;

   localparam int WIDTH   = 8;
   localparam int N       = 9;
   localparam int TIMEOUT = 63;

   logic             CLK;
   logic             nRST;
   logic [WIDTH-1:0] PIX_IN;
   logic             PIX_VALID;
   logic             PIX_READY;
   logic [WIDTH-1:0] MED_DI;
   logic             MED_DSI;
   logic [WIDTH-1:0] MED_DO;
   logic             MED_DSO;
   logic [WIDTH-1:0] RES;
   logic             RES_VALID;
   logic             RES_READY;
   logic             ERR;
   logic             BUSY;

   int checks;
   int errors;
   logic expErr;
   logic [WIDTH-1:0] win [N];

   med_feeder #(.WIDTH(WIDTH), .N(N), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .nRST(nRST),
      .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
      .MED_DI(MED_DI), .MED_DSI(MED_DSI),
      .MED_DO(MED_DO), .MED_DSO(MED_DSO),
      .RES(RES), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
      .ERR(ERR), .BUSY(BUSY)
   );

   // Free-running clock, period 10
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One comparison: counts it, and on a miss counts and reports the failure
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and land 1 time unit after the rising edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // True median of the current window, by sorting a copy
   function automatic logic [WIDTH-1:0] medianOf();
      logic [WIDTH-1:0] s [N];
      logic [WIDTH-1:0] t;
      for (int i = 0; i < N; i++) s[i] = win[i];
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N - 1 - i; j++)
            if (s[j] > s[j+1]) begin
               t = s[j]; s[j] = s[j+1]; s[j+1] = t;
            end
      return s[N/2];
   endfunction

   task automatic randomWindow();
      for (int i = 0; i < N; i++) win[i] = WIDTH'($urandom);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_pix_ready"}, PIX_READY, 1);
      checkOutput({tag, "_busy"},      BUSY,      0);
      checkOutput({tag, "_err"},       ERR,       0);
      checkOutput({tag, "_res"},       RES,       0);
      checkOutput({tag, "_res_valid"}, RES_VALID, 0);
      checkOutput({tag, "_dsi"},       MED_DSI,   0);
      checkOutput({tag, "_di"},        MED_DI,    0);
   endtask

   // Feed the window upstream. gapMode 0: continuous valid; 1: an idle
   // cycle (with a spurious engine strobe) before every pixel after the
   // first; 2: random idle cycles.
   task automatic applyStimulus(input int gapMode);
      bit gap;
      for (int i = 0; i < N; i++) begin
         gap = (gapMode == 1 && i > 0) || (gapMode == 2 && $urandom_range(0, 2) == 0);
         if (gap) begin
            PIX_VALID = 1'b0;
            PIX_IN    = 8'hEE;
            MED_DSO   = 1'b1;
            MED_DO    = 8'h77;
            tick();
            MED_DSO   = 1'b0;
            checkOutput("gap_no_send", MED_DSI, 0);
            checkOutput("gap_no_result", RES_VALID, 0);
         end
         checkOutput("fill_ready", PIX_READY, 1);
         PIX_VALID = 1'b1;
         PIX_IN    = win[i];
         tick();
      end
      PIX_VALID = 1'b0;
      PIX_IN    = '0;
      checkOutput("after_fill_ready", PIX_READY, 0);
      checkOutput("after_fill_busy",  BUSY,      1);
   endtask

   // Expect the window replayed in order on consecutive strobe cycles
   task automatic checkSend();
      for (int i = 0; i < N; i++) begin
         checkOutput("send_dsi", MED_DSI, 1);
         checkOutput($sformatf("send_di%0d", i), MED_DI, win[i]);
         tick();
      end
      checkOutput("wait_dsi", MED_DSI, 0);
      checkOutput("wait_di",  MED_DI,  0);
   endtask

   // Engine answers on WAIT cycle 'delay' (0-based). Loop is bounded by
   // TIMEOUT+1 cycles, when the window must have either finished or timed out.
   task automatic waitEngine(input int delay, input logic [WIDTH-1:0] doVal,
                             output bit captured);
      captured = 1'b0;
      for (int t = 0; t <= TIMEOUT; t++) begin
         MED_DSO = (t == delay);
         MED_DO  = (t == delay) ? doVal : 8'h33;
         tick();
         MED_DSO = 1'b0;
         if (t == delay) begin
            captured = 1'b1;
            checkOutput("cap_res_valid", RES_VALID, 1);
            checkOutput("cap_res",       RES,       doVal);
            checkOutput("cap_err",       ERR,       expErr);
            checkOutput("cap_pix_ready", PIX_READY, 0);
            return;
         end
         if (t == TIMEOUT) begin
            expErr = 1'b1;
            checkOutput("to_err",       ERR,       1);
            checkOutput("to_pix_ready", PIX_READY, 1);
            checkOutput("to_busy",      BUSY,      0);
            checkOutput("to_res_valid", RES_VALID, 0);
            return;
         end
      end
   endtask

   // Hold the result for some cycles with no downstream accept, then accept
   task automatic holdResult(input int cycles, input logic [WIDTH-1:0] expRes);
      RES_READY = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         MED_DSO = 1'b1;
         MED_DO  = ~expRes;
         tick();
         MED_DSO = 1'b0;
         checkOutput("hold_res",       RES,       expRes);
         checkOutput("hold_res_valid", RES_VALID, 1);
         checkOutput("hold_pix_ready", PIX_READY, 0);
      end
      RES_READY = 1'b1;
      tick();
      RES_READY = 1'b0;
      checkOutput("release_res_valid", RES_VALID, 0);
      checkOutput("release_pix_ready", PIX_READY, 1);
      checkOutput("release_busy",      BUSY,      0);
      checkOutput("release_err",       ERR,       expErr);
   endtask

   // Full window: fill, replay, engine answer with the median, drain
   task automatic runWindow(input int gapMode, input int delay, input int hold);
      bit cap;
      logic [WIDTH-1:0] m;
      m = medianOf();
      applyStimulus(gapMode);
      checkSend();
      waitEngine(delay, m, cap);
      if (cap) holdResult(hold, m);
   endtask

   initial begin
      bit cap;
      checks    = 0;
      errors    = 0;
      expErr    = 1'b0;
      nRST      = 1'b0;
      PIX_IN    = '0;
      PIX_VALID = 1'b0;
      MED_DO    = '0;
      MED_DSO   = 1'b0;
      RES_READY = 1'b0;

      // Reset state
      tick();
      tick();
      checkReset("reset");
      nRST = 1'b1;
      tick();

      // Known stream 9,1,8,2,7,3,6,4,5 -> median 5, held 20 cycles
      win = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
      applyStimulus(0);
      checkSend();
      waitEngine(2, 8'd5, cap);
      checkOutput("known_captured", 32'(cap), 1);
      holdResult(20, 8'd5);

      // Silent engine -> timeout, then a following window still completes
      randomWindow();
      applyStimulus(0);
      checkSend();
      waitEngine(TIMEOUT + 10, 8'h00, cap);
      checkOutput("silent_not_captured", 32'(cap), 0);
      randomWindow();
      runWindow(0, 5, 3);
      checkOutput("err_sticky", ERR, 1);

      // Reset clears ERR; strobe exactly at the timeout boundary wins
      nRST = 1'b0;
      #1;
      expErr = 1'b0;
      checkReset("reset2");
      tick();
      nRST = 1'b1;
      tick();
      randomWindow();
      applyStimulus(0);
      checkSend();
      waitEngine(TIMEOUT, 8'hAA, cap);
      checkOutput("boundary_captured", 32'(cap), 1);
      checkOutput("boundary_err", ERR, 0);
      holdResult(1, 8'hAA);

      // Alternating PIX_VALID with spurious strobes during fill
      randomWindow();
      runWindow(1, 0, 0);

      // Randomized windows, gaps, engine delays (some timing out) and holds
      for (int k = 0; k < 8; k++) begin
         randomWindow();
         runWindow(2, int'($urandom_range(0, TIMEOUT + 8)), int'($urandom_range(0, 5)));
      end

      // Reset on the 4th replay cycle: strobe drops at once, window lost
      randomWindow();
      applyStimulus(0);
      tick();
      tick();
      tick();
      checkOutput("midsend_dsi", MED_DSI, 1);
      checkOutput("midsend_di",  MED_DI,  win[3]);
      nRST = 1'b0;
      #1;
      expErr = 1'b0;
      checkReset("midsend_reset");
      tick();
      nRST = 1'b1;
      tick();
      checkOutput("post_reset_dsi", MED_DSI, 0);

      // Block works normally after the interrupted window
      randomWindow();
      runWindow(0, 7, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
